// File: rtl/image_window_crop_pkg.sv
// image_crop_pkg: shared types for the image window cropper.
//   CNT_W          default width of X/Y counters and window fields
//   crop_state_e   frame FSM encoding (IDLE=0, ACTIVE=1)
//   crop_window_t  shadowed window {x_start, x_end, y_start, y_end}
package image_crop_pkg;

  localparam int CNT_W = 12;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } crop_state_e;

  // Field width is fixed at CNT_W; a top-level CNT_WIDTH override must match.
  typedef struct packed {
    logic [CNT_W-1:0] x_start;
    logic [CNT_W-1:0] x_end;
    logic [CNT_W-1:0] y_start;
    logic [CNT_W-1:0] y_end;
  } crop_window_t;

  // Empty or inverted window on either axis.
  function automatic logic window_invalid(input crop_window_t w);
    return (w.x_start >= w.x_end) || (w.y_start >= w.y_end);
  endfunction

endpackage

// File: rtl/image_window_crop_if.sv
// image_window_crop_if: one raster video stream with vsync/href/de framing.
//   vsync  frame active
//   href   line active
//   de     pixel valid within href
//   data   NUM_CH pixels, channel 0 in the LSBs
// master drives the stream, slave receives it.
interface image_window_crop_if #(
  parameter int NUM_CH           = 2,
  parameter int PIXEL_DATA_WIDTH = 8
);
  logic                               vsync;
  logic                               href;
  logic                               de;
  logic [NUM_CH*PIXEL_DATA_WIDTH-1:0] data;

  modport master (output vsync, href, de, data);
  modport slave  (input  vsync, href, de, data);
endinterface

// File: rtl/image_window_crop_pos_counter.sv
// image_pos_counter: saturating pixel/line position generator.
//   clk, rst_n   pixel clock, async active-low reset
//   href_i/de_i  input line framing
//   active_i     frame active this cycle (ACTIVE state and vsync still high)
//   xpos_o       valid pixels already seen in the current line
//   ypos_o       lines already completed in the current frame
// Both outputs are registers, so during a pixel they hold the count before it.
module image_pos_counter
  import image_crop_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 href_i,
  input  logic                 de_i,
  input  logic                 active_i,
  output logic [CNT_WIDTH-1:0] xpos_o,
  output logic [CNT_WIDTH-1:0] ypos_o
);

  logic                 href_q;
  logic [CNT_WIDTH-1:0] xpos_q, xpos_d;
  logic [CNT_WIDTH-1:0] ypos_q, ypos_d;
  logic                 href_fall;

  assign href_fall = href_q & ~href_i;

  always_comb begin
    xpos_d = '0;
    if (href_i) begin
      xpos_d = xpos_q;
      if (de_i && (xpos_q != '1)) xpos_d = xpos_q + CNT_WIDTH'(1);
    end

    // A vsync fall drops active_i, so a coincident href fall clears ypos.
    ypos_d = ypos_q;
    if (!active_i) begin
      ypos_d = '0;
    end else if (href_fall && (ypos_q != '1)) begin
      ypos_d = ypos_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q <= 1'b0;
      xpos_q <= '0;
      ypos_q <= '0;
    end else begin
      href_q <= href_i;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
    end
  end

  assign xpos_o = xpos_q;
  assign ypos_o = ypos_q;

endmodule

// File: rtl/image_window_crop.sv
// image_window_crop: crops a runtime-configured window out of a multi-channel
// raster stream. Window config is shadowed at vsync rise; all outputs are
// registered with one cycle of latency.
//   clk, rst_n            pixel clock, async active-low reset
//   image_in              input stream (slave)
//   image_out             cropped stream (master); data is not zeroed, qualify with de
//   cfg_x/y_start/_end    window [start, end) on each axis
//   frame_done            one-cycle pulse after vsync fall
//   crop_lines            out_href lines emitted in the last completed frame
//   cfg_err               shadow window invalid for the current frame
//
// state  | meaning
// IDLE   | between frames, waiting for vsync rise
// ACTIVE | frame in progress, window shadow valid
module image_window_crop
  import image_crop_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int PIXEL_DATA_WIDTH = 8,
  parameter int CNT_WIDTH        = CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  image_window_crop_if.slave   image_in,
  image_window_crop_if.master  image_out,
  input  logic [CNT_WIDTH-1:0] cfg_x_start,
  input  logic [CNT_WIDTH-1:0] cfg_x_end,
  input  logic [CNT_WIDTH-1:0] cfg_y_start,
  input  logic [CNT_WIDTH-1:0] cfg_y_end,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] crop_lines,
  output logic                 cfg_err
);

  localparam int DW = NUM_CH * PIXEL_DATA_WIDTH;

  crop_state_e          state_q, state_d;
  logic                 vsync_q;
  crop_window_t         win_q, win_d, cfg_win;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0] crop_lines_q, crop_lines_d;
  logic                 frame_done_q, frame_done_d;
  logic                 out_vsync_q;
  logic                 out_href_q, out_href_d;
  logic                 out_de_q, out_de_d;
  logic [DW-1:0]        out_data_q;

  logic                 vsync_rise, vsync_fall, active;
  logic [CNT_WIDTH-1:0] xpos, ypos;
  logic                 in_x, in_y;

  assign vsync_rise = image_in.vsync & ~vsync_q;
  assign vsync_fall = ~image_in.vsync & vsync_q;
  // Gating on live vsync forces the output low on the very cycle vsync falls.
  assign active     = (state_q == ACTIVE) & image_in.vsync;

  assign cfg_win = '{x_start: cfg_x_start, x_end: cfg_x_end,
                     y_start: cfg_y_start, y_end: cfg_y_end};

  image_pos_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .href_i   (image_in.href),
    .de_i     (image_in.de),
    .active_i (active),
    .xpos_o   (xpos),
    .ypos_o   (ypos)
  );

  assign in_x = (xpos >= win_q.x_start) && (xpos < win_q.x_end);
  assign in_y = (ypos >= win_q.y_start) && (ypos < win_q.y_end);

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    crop_lines_d = crop_lines_q;
    line_cnt_d   = line_cnt_q;

    out_href_d = image_in.href & in_y & active & ~err_q;
    out_de_d   = image_in.de & in_x & out_href_d;

    if (out_href_q && !out_href_d) line_cnt_d = line_cnt_q + CNT_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (vsync_rise) begin
          state_d    = ACTIVE;
          win_d      = cfg_win;
          err_d      = window_invalid(cfg_win);
          line_cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (vsync_fall) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          // A line cut short by vsync still counts: it did emit pixels.
          crop_lines_d = line_cnt_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      // Treat vsync as already high so a frame in flight at release is skipped.
      vsync_q      <= 1'b1;
      win_q        <= '0;
      err_q        <= 1'b0;
      line_cnt_q   <= '0;
      crop_lines_q <= '0;
      frame_done_q <= 1'b0;
      out_vsync_q  <= 1'b0;
      out_href_q   <= 1'b0;
      out_de_q     <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= image_in.vsync;
      win_q        <= win_d;
      err_q        <= err_d;
      line_cnt_q   <= line_cnt_d;
      crop_lines_q <= crop_lines_d;
      frame_done_q <= frame_done_d;
      out_vsync_q  <= image_in.vsync;
      out_href_q   <= out_href_d;
      out_de_q     <= out_de_d;
      out_data_q   <= image_in.data;
    end
  end

  assign image_out.vsync = out_vsync_q;
  assign image_out.href  = out_href_q;
  assign image_out.de    = out_de_q;
  assign image_out.data  = out_data_q;
  assign frame_done      = frame_done_q;
  assign crop_lines      = crop_lines_q;
  assign cfg_err         = err_q;

endmodule

// File: tb/tb_image_window_crop.sv
module tb_image_window_crop;
  import image_crop_pkg::*;

  localparam int NUM_CH = 2;
  localparam int PW     = 8;
  localparam int CW     = 12;
  localparam int DW     = NUM_CH * PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] cfg_x_start = '0, cfg_x_end = '0, cfg_y_start = '0, cfg_y_end = '0;
  logic          frame_done, cfg_err;
  logic [CW-1:0] crop_lines;

  image_window_crop_if #(.NUM_CH(NUM_CH), .PIXEL_DATA_WIDTH(PW)) vin ();
  image_window_crop_if #(.NUM_CH(NUM_CH), .PIXEL_DATA_WIDTH(PW)) vout ();

  image_window_crop #(.NUM_CH(NUM_CH), .PIXEL_DATA_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .image_in    (vin),
    .image_out   (vout),
    .cfg_x_start (cfg_x_start),
    .cfg_x_end   (cfg_x_end),
    .cfg_y_start (cfg_y_start),
    .cfg_y_end   (cfg_y_end),
    .frame_done  (frame_done),
    .crop_lines  (crop_lines),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_href_cyc = -1;
  int fd_cnt = 0;
  int drop_cyc = 0;
  int exp_lines = 0;
  bit m_err = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] nx_xs = '0, nx_xe = '0, nx_ys = '0, nx_ye = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation only: collect emitted pixels, frame_done pulses, last href cycle.
  always @(negedge clk) begin
    if (vout.de === 1'b1) got_q.push_back(vout.data);
    if (frame_done === 1'b1) fd_cnt++;
    if (vout.href === 1'b1) last_href_cyc = cyc;
  end

  initial begin
    vin.vsync = 1'b0;
    vin.href  = 1'b0;
    vin.de    = 1'b0;
    vin.data  = '0;
  end

  task automatic drive(input logic v, input logic h, input logic d, input logic [DW-1:0] dat);
    @(negedge clk);
    vin.vsync = v;
    vin.href  = h;
    vin.de    = d;
    vin.data  = dat;
  endtask

  task automatic set_cfg(input int xs, input int xe, input int ys, input int ye);
    cfg_x_start = CW'(xs);
    cfg_x_end   = CW'(xe);
    cfg_y_start = CW'(ys);
    cfg_y_end   = CW'(ye);
  endtask

  task automatic clear_obs();
    @(posedge clk);
    #1;
    got_q.delete();
    fd_cnt = 0;
  endtask

  function automatic bit queues_equal();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: a pixel is expected when the window latched at vsync rise is
  // valid, the line index is in [ys,ye) and its valid-pixel index is in [xs,xe).
  // stop_mode 1 drops vsync at (stop_line, stop_px); 2 returns there for a reset.
  task automatic drive_frame(input int w, input int h, input bit gapped, input int chg_line,
                             input int stop_line, input int stop_px, input int stop_mode);
    int xs, xe, ys, ye, k, ph;
    bit valid;
    logic d;
    logic [DW-1:0] dat;
    exp_q.delete();
    exp_lines = 0;
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    xs = int'(cfg_x_start); xe = int'(cfg_x_end);
    ys = int'(cfg_y_start); ye = int'(cfg_y_end);
    m_err = !((xs < xe) && (ys < ye));
    valid = !m_err;
    repeat (3) drive(1'b1, 1'b0, 1'b0, '0);
    for (int l = 0; l < h; l++) begin
      if (l == chg_line) begin
        cfg_x_start = nx_xs; cfg_x_end = nx_xe;
        cfg_y_start = nx_ys; cfg_y_end = nx_ye;
      end
      k = 0;
      ph = 0;
      while (k < w) begin
        if (stop_mode != 0 && l == stop_line && k == stop_px) begin
          if (stop_mode == 1) begin
            drive(1'b0, 1'b1, 1'b1, DW'($urandom));
            drop_cyc = cyc;
            for (int r = k + 1; r < w; r++) drive(1'b0, 1'b1, 1'b1, DW'($urandom));
            repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
          end
          return;
        end
        d = (!gapped || (ph % 2 == 0));
        dat = DW'($urandom);
        drive(1'b1, 1'b1, d, dat);
        if (ph == 0 && valid && l >= ys && l < ye) exp_lines++;
        if (d) begin
          if (valid && l >= ys && l < ye && k >= xs && k < xe) exp_q.push_back(dat);
          k++;
        end
        ph++;
      end
      repeat (2) drive(1'b1, 1'b0, 1'b0, '0);
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    #3;
    if ({vout.vsync, vout.href, vout.de, vout.data, frame_done, crop_lines, cfg_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got vs=%b hr=%b de=%b data=%h fd=%b cl=%0d err=%b exp all 0",
               vout.vsync, vout.href, vout.de, vout.data, frame_done, crop_lines, cfg_err);
    end
    n_tests++;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic v, h, d;
    logic [DW-1:0] dat;
    for (int i = 0; i < 24; i++) begin
      v = 1'($urandom); h = 1'($urandom); d = 1'($urandom); dat = DW'($urandom);
      drive(v, h, d, dat);
      @(posedge clk);
      #1;
      if (vout.data !== dat || vout.vsync !== v) begin
        n_fail++;
        $display("FAIL latency cycle %0d got data=%h vs=%b exp data=%h vs=%b", i, vout.data, vout.vsync, dat, v);
      end
      n_tests++;
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_basic();
    set_cfg(4, 12, 2, 6);
    clear_obs();
    drive_frame(16, 8, 1'b0, -1, -1, -1, 0);
    if (got_q.size() != 32) begin
      n_fail++; $display("FAIL basic_count got %0d pixels exp 32", got_q.size());
    end
    n_tests++;
    if (!queues_equal()) begin
      n_fail++; $display("FAIL basic_data got %0d pixels exp %0d, contents differ", got_q.size(), exp_q.size());
    end
    n_tests++;
    if (crop_lines !== CW'(4) || fd_cnt != 1 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_status got cl=%0d fd=%0d err=%b exp cl=4 fd=1 err=0", crop_lines, fd_cnt, cfg_err);
    end
    n_tests++;
  endtask

  task automatic test_cfg_midframe();
    set_cfg(4, 12, 2, 6);
    nx_xs = CW'(0); nx_xe = CW'(16); nx_ys = CW'(0); nx_ye = CW'(8);
    clear_obs();
    drive_frame(16, 8, 1'b0, 3, -1, -1, 0);
    if (got_q.size() != 32 || !queues_equal() || crop_lines !== CW'(4)) begin
      n_fail++; $display("FAIL midcfg_current got %0d px cl=%0d exp 32 px cl=4", got_q.size(), crop_lines);
    end
    n_tests++;
    clear_obs();
    drive_frame(16, 8, 1'b0, -1, -1, -1, 0);
    if (got_q.size() != 128 || !queues_equal()) begin
      n_fail++; $display("FAIL midcfg_next_data got %0d px exp 128", got_q.size());
    end
    n_tests++;
    if (crop_lines !== CW'(8) || fd_cnt != 1) begin
      n_fail++; $display("FAIL midcfg_next_status got cl=%0d fd=%0d exp cl=8 fd=1", crop_lines, fd_cnt);
    end
    n_tests++;
  endtask

  task automatic test_cfg_err();
    set_cfg(10, 10, 2, 6);
    clear_obs();
    drive_frame(16, 8, 1'b0, -1, -1, -1, 0);
    if (cfg_err !== 1'b1 || got_q.size() != 0 || crop_lines !== CW'(0) || fd_cnt != 1) begin
      n_fail++; $display("FAIL cfgerr_frame got err=%b px=%0d cl=%0d fd=%0d exp err=1 px=0 cl=0 fd=1",
                         cfg_err, got_q.size(), crop_lines, fd_cnt);
    end
    n_tests++;
    set_cfg(4, 12, 2, 6);
    clear_obs();
    drive_frame(16, 8, 1'b0, -1, -1, -1, 0);
    if (cfg_err !== 1'b0 || got_q.size() != 32 || !queues_equal()) begin
      n_fail++; $display("FAIL cfgerr_recover got err=%b px=%0d exp err=0 px=32", cfg_err, got_q.size());
    end
    n_tests++;
  endtask

  task automatic test_gapped();
    set_cfg(2, 5, 0, 8);
    clear_obs();
    drive_frame(8, 4, 1'b1, -1, -1, -1, 0);
    if (got_q.size() != 12 || !queues_equal()) begin
      n_fail++; $display("FAIL gapped_data got %0d px exp 12 (pixels 3..5 of each line)", got_q.size());
    end
    n_tests++;
    if (crop_lines !== CW'(4)) begin
      n_fail++; $display("FAIL gapped_lines got %0d exp 4", crop_lines);
    end
    n_tests++;
  endtask

  task automatic test_vsync_drop();
    set_cfg(4, 12, 2, 6);
    clear_obs();
    drive_frame(16, 8, 1'b0, -1, 2, 6, 1);
    if (last_href_cyc != drop_cyc) begin
      n_fail++; $display("FAIL drop_href_timing got last href cycle %0d exp %0d", last_href_cyc, drop_cyc);
    end
    n_tests++;
    if (fd_cnt != 1 || crop_lines !== CW'(1) || !queues_equal()) begin
      n_fail++; $display("FAIL drop_status got fd=%0d cl=%0d px=%0d exp fd=1 cl=1 px=%0d",
                         fd_cnt, crop_lines, got_q.size(), exp_q.size());
    end
    n_tests++;
    clear_obs();
    drive_frame(16, 8, 1'b0, -1, -1, -1, 0);
    if (got_q.size() != 32 || !queues_equal() || crop_lines !== CW'(4)) begin
      n_fail++; $display("FAIL drop_next got %0d px cl=%0d exp 32 px cl=4", got_q.size(), crop_lines);
    end
    n_tests++;
  endtask

  task automatic test_reset_midframe();
    set_cfg(4, 12, 2, 6);
    clear_obs();
    drive_frame(16, 8, 1'b0, -1, 3, 7, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if ({vout.vsync, vout.href, vout.de, vout.data, frame_done, crop_lines, cfg_err} !== '0) begin
      n_fail++; $display("FAIL midreset_async got vs=%b hr=%b de=%b data=%h fd=%b cl=%0d exp all 0",
                         vout.vsync, vout.href, vout.de, vout.data, frame_done, crop_lines);
    end
    n_tests++;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 16; p++) drive(1'b1, 1'b1, 1'b1, DW'($urandom));
      repeat (2) drive(1'b1, 1'b0, 1'b0, '0);
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    if (!queues_equal() || fd_cnt != 0 || crop_lines !== CW'(0)) begin
      n_fail++; $display("FAIL midreset_partial got px=%0d fd=%0d cl=%0d exp px=%0d fd=0 cl=0",
                         got_q.size(), fd_cnt, crop_lines, exp_q.size());
    end
    n_tests++;
    clear_obs();
    drive_frame(16, 8, 1'b0, -1, -1, -1, 0);
    if (got_q.size() != 32 || !queues_equal() || crop_lines !== CW'(4) || fd_cnt != 1) begin
      n_fail++; $display("FAIL midreset_next got px=%0d cl=%0d fd=%0d exp 32 4 1", got_q.size(), crop_lines, fd_cnt);
    end
    n_tests++;
  endtask

  task automatic test_random();
    int w, h;
    bit g;
    for (int f = 0; f < 8; f++) begin
      w = $urandom_range(4, 20);
      h = $urandom_range(2, 10);
      g = 1'($urandom);
      set_cfg($urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 12), $urandom_range(0, 12));
      clear_obs();
      drive_frame(w, h, g, -1, -1, -1, 0);
      if (!queues_equal()) begin
        n_fail++; $display("FAIL random_data frame %0d got %0d px exp %0d", f, got_q.size(), exp_q.size());
      end
      n_tests++;
      if (crop_lines !== CW'(exp_lines) || cfg_err !== m_err || fd_cnt != 1) begin
        n_fail++; $display("FAIL random_status frame %0d got cl=%0d err=%b fd=%0d exp cl=%0d err=%b fd=1",
                           f, crop_lines, cfg_err, fd_cnt, exp_lines, m_err);
      end
      n_tests++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_cfg_midframe();
    test_cfg_err();
    test_gapped();
    test_vsync_drop();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/image_window_crop.md
# image_window_crop

Runtime-configurable crop of a rectangular window from a raster video stream with vsync/href/de framing. It is the next-generation cropper for the stitching pipeline and carries NUM_CH parallel channels (e.g. left/right sensors) that share one timing. Window coordinates come from software, are shadowed, and take effect only at frame start. The block sits between sensor capture and the stitching/overlap logic, and reports per-frame status.

## Interface
- NUM_CH, 2: channels sharing one timing stream.
- PIXEL_DATA_WIDTH, 8: bits per channel pixel.
- CNT_WIDTH, 12: width of X/Y counters and config fields.
- Reset is `rst_n`, asynchronous, active-low; the clock is `clk`.
- clk  in  1  pixel clock.
- rst_n  in  1  async active-low reset.
- image_in_vsync  in  1  high = frame active.
- image_in_href  in  1  high = line active.
- image_in_de  in  1  pixel valid within href.
- image_in_data  in  NUM_CH*PIXEL_DATA_WIDTH  channel 0 in LSBs.
- cfg_x_start, cfg_x_end  in  CNT_WIDTH each  window columns [start, end).
- cfg_y_start, cfg_y_end  in  CNT_WIDTH each  window lines [start, end).
- image_out_vsync  out  1  delayed vsync.
- image_out_href  out  1  line active inside Y window.
- image_out_de  out  1  pixel inside X and Y window.
- image_out_data  out  NUM_CH*PIXEL_DATA_WIDTH  delayed data.
- frame_done  out  1  one-cycle pulse at frame end.
- crop_lines  out  CNT_WIDTH  lines emitted in the last completed frame.
- cfg_err  out  1  shadow window invalid for the current frame.

## Operation
- FSM with two states: IDLE and ACTIVE.
  - IDLE -> ACTIVE on a vsync rising edge. On that edge, cfg_* are latched into shadow registers.
  - ACTIVE -> IDLE on a vsync falling edge. On that edge, frame_done pulses and crop_lines takes the value of the emitted-line counter.
- cfg_err is set at latch time if x_start >= x_end or y_start >= y_end. While cfg_err is set, out_href and out_de stay low for the whole frame.
- xpos:
  - Cleared whenever href is low.
  - Increments on each de cycle within href.
  - Saturates at all-ones; no wrap.
- ypos:
  - Cleared in IDLE.
  - Increments on each href falling edge in ACTIVE.
  - Saturates at all-ones.
- Window tests use the pre-increment counter values:
  - in_y: y_start <= ypos < y_end.
  - in_x: x_start <= xpos < x_end.
- Output equations:
  - out_href = href & in_y & ACTIVE & !cfg_err.
  - out_de = de & in_x & out_href condition.
- Data passes through for all cycles and is not zeroed. Consumers must qualify it with out_de.
- The emitted-line counter increments on each out_href falling edge.

## Timing
- All outputs are registered. Latency is exactly 1 cycle, equal for vsync, href, de and data.
- Reset value of every output is 0. FSM resets to IDLE, counters and shadows to 0.
- A config change mid-frame has no effect until the next vsync rise.
- If vsync falls mid-line: return to IDLE the same cycle, and force out_href/out_de low from the next output cycle. frame_done still pulses.
- Lines shorter than x_end truncate the window with no error. Windows extending past the frame end likewise emit fewer lines; crop_lines reflects the actual count.
- If an href falling edge and a vsync falling edge coincide, the vsync edge wins and ypos clears.
- If rst_n is asserted mid-frame, all outputs go to 0 asynchronously. After release, wait for the next vsync rise; there is no partial-frame output.

## Structure
- Package image_crop_pkg holds:
  - the CNT_WIDTH default;
  - the FSM state encoding (IDLE=0, ACTIVE=1);
  - the window shadow struct {x_start, x_end, y_start, y_end}.
- Sub-module image_pos_counter: the saturating xpos/ypos generator with edge detection. Its output, the pos pair, is registered.
- Top level: FSM, shadow latch, window compare, output registers and status.

## Test plan
- Frame 16x8, cfg x[4,12) y[2,6), NUM_CH=2 -> 4 lines of 8 out_de each. Data equals the input delayed 1 cycle; crop_lines=4; one frame_done.
- cfg rewritten to x[0,16) y[0,8) mid-frame -> current frame unchanged (4x8). The next frame emits 8 lines of 16.
- cfg x_start=10, x_end=10 -> cfg_err=1, zero out_de for that frame. Restoring a valid cfg clears cfg_err at the next vsync rise.
- Gapped de (de toggling every other cycle) with x[2,5) -> exactly the 3rd-5th valid pixels emitted per line.
- vsync dropped during line 3 of y[2,6) -> out_href low 1 cycle later, frame_done pulses, crop_lines=1. The next frame is normal.
- rst_n pulsed mid-line -> all outputs 0 immediately, no output until a fresh vsync rise, then a correct crop.
